// File: rtl/pc_unit_if.sv
// Fetch-front bus between the sequencer and the program counter unit.
// Carries the per-cycle command (en/op/target/offset) and the PC / RAS status back.
// stack_err exists only when PC_STACK_ERR_EN is defined.
interface pc_unit_if #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int CW = $clog2(STACK_DEPTH) + 1;

  // command from the sequencer
  logic             en;
  logic [2:0]       op;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] offset;

  // status back from the PC unit
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] pc_next;
  logic [CW-1:0]    stack_cnt;
  logic             stack_full;
  logic             stack_empty;
`ifdef PC_STACK_ERR_EN
  logic             stack_err;
`endif

  modport master (
    output en, op, target, offset,
    input  q, pc_next, stack_cnt, stack_full, stack_empty
`ifdef PC_STACK_ERR_EN
    , input stack_err
`endif
  );

  modport slave (
    input  en, op, target, offset,
    output q, pc_next, stack_cnt, stack_full, stack_empty
`ifdef PC_STACK_ERR_EN
    , output stack_err
`endif
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with return-address stack: INC / JMP / BRA / CALL / RET, one op per enabled cycle.
// Latency: q updates one edge after the command is sampled; pc_next shows that value combinationally.
// Backpressure: none; en=0 (or a reserved op) stalls and holds every piece of state.
// Optional feature: define PC_STACK_ERR_EN to add the sticky stack_err overflow/underflow flag.
module pc_unit #(
  parameter int               WIDTH       = 8,
  parameter int               STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0,
  parameter logic [WIDTH-1:0] INC         = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input logic      clk,
  input logic      reset_n,
  pc_unit_if.slave bus
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    OP_INC  = 3'b000,
    OP_JMP  = 3'b001,
    OP_BRA  = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100
  } op_e;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] ret_addr;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] ras [STACK_DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    wp_inc;
  logic [PW-1:0]    wp_dec;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;
  op_e              op_c;

  // Fall-through address: what INC lands on and what CALL saves for the return.
  assign ret_addr = q_r + INC;
  assign wp_inc   = wp + PW'(1);
  assign wp_dec   = wp - PW'(1);
  assign ras_top  = ras[wp_dec];
  assign full     = (cnt == CW'(STACK_DEPTH));
  assign empty    = (cnt == '0);
  assign op_c     = op_e'(bus.op);

  // Decode the command into the next PC and the stack action; reserved ops fall to hold.
  always_comb begin
    pc_nxt  = q_r;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (bus.en) begin
      case (op_c)
        OP_INC:  pc_nxt = ret_addr;
        OP_JMP:  pc_nxt = bus.target;
        OP_BRA:  pc_nxt = q_r + bus.offset;
        OP_CALL: begin
          pc_nxt  = bus.target;
          do_push = 1'b1;
        end
        OP_RET: begin
          // An empty stack has nothing to return to, so just step past the RET.
          if (empty) begin
            pc_nxt = ret_addr;
          end else begin
            pc_nxt = ras_top;
            do_pop = 1'b1;
          end
        end
        default: pc_nxt = q_r;
      endcase
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r <= RESET_VEC;
    end else begin
      q_r <= pc_nxt;
    end
  end

  // Stack pointer and occupancy; a push while full wraps over the oldest entry without counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp  <= '0;
      cnt <= '0;
    end else if (do_push) begin
      wp <= wp_inc;
      if (!full) begin
        cnt <= cnt + CW'(1);
      end
    end else if (do_pop) begin
      wp  <= wp_dec;
      cnt <= cnt - CW'(1);
    end
  end

  // Return-address storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ras[wp] <= ret_addr;
    end
  end

`ifdef PC_STACK_ERR_EN
  logic err_r;

  // Sticky misuse flag: CALL into a full stack or RET from an empty one; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_r <= 1'b0;
    end else if (bus.en && ((op_c == OP_CALL && full) || (op_c == OP_RET && empty))) begin
      err_r <= 1'b1;
    end
  end

  assign bus.stack_err = err_r;
`endif

  assign bus.q           = q_r;
  assign bus.pc_next     = pc_nxt;
  assign bus.stack_cnt   = cnt;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;

  // Occupancy can never exceed the depth, and full/empty are mutually exclusive.
  a_cnt_range : assert property (@(posedge clk) disable iff (!reset_n) cnt <= CW'(STACK_DEPTH));
  a_full_empty : assert property (@(posedge clk) disable iff (!reset_n) !(full && empty));

endmodule
